aes_inv_key_schedule: RTL
=========================

# aes_inv_key_schedule

Sequential AES-128 key-schedule unit for the decryption datapath. It accepts the cipher key and expands it forward, one round per cycle, to the round-10 key. It then walks the schedule backwards, presenting round keys 10, 9, …, 0 over a valid/ready stream in the order the inverse cipher consumes them. It is the decrypt-side counterpart of the combinational forward round-key generator and reuses the shared `sbox` module (ports `a` in, `c` out).

## Interface
Parameters: none (AES-128 only, 10 rounds fixed).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; honoured only in IDLE; captures `key_in`.
- `key_in`  in  128  cipher key (round-0 key); word 0 is [127:96].
- `busy`  out  1  high in every state other than IDLE.
- `rk_valid`  out  1  `rk_out`/`rk_round` hold a valid round key.
- `rk_ready`  in  1  consumer accepts the key on a cycle where `rk_valid & rk_ready`.
- `rk_out`  out  128  current round key, same word ordering as `key_in`.
- `rk_round`  out  4  round index of `rk_out` (10 down to 0).
- `done`  out  1  one-cycle pulse after round key 0 is accepted.

## Operation
- State register `key_r`[127:0] drives `rk_out` directly. Round counter `rnd`[3:0] drives `rk_round`.
- Four `sbox` instances are shared by both phases. Their input is always word 3 of the current `key_r`, rotated: bytes [23:16], [15:8], [7:0], [31:24] feed the instances whose outputs form `t`[31:24] … [7:0].
- `rcon(i)` for i = 0..9 is 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36 in bits [31:24], with zeros below. The index is always 0..9 when used.
- Forward step with index i: w0' = w0^t^rcon(i); w1' = w0'^w1; w2' = w1'^w2; w3' = w2'^w3.
- Inverse step with index i: w3 = w3'^w2'; w2 = w2'^w1'; w1 = w1'^w0'. Then t is computed from the recovered w3, and w0 = w0'^t^rcon(i).
- Because the inverse step needs t from the recovered w3, the sbox input mux selects `key_r`[31:0] in EXPAND and `key_r`[63:32]^`key_r`[31:0] in OUTPUT.
- States:
  - IDLE. On `start`: `key_r` ← `key_in`, `rnd` ← 0, go to EXPAND.
  - EXPAND. Each cycle applies a forward step with i = `rnd`, then `rnd` ← `rnd`+1. On the cycle where `rnd` = 9: `key_r` ← K10, `rnd` ← 10, go to OUTPUT.
  - OUTPUT. `rk_valid` = 1.
    - Accept with `rnd` > 0: inverse step with i = `rnd`−1, `rnd` ← `rnd`−1, remain in OUTPUT.
    - Accept with `rnd` = 0: go to IDLE, `done` = 1 for one cycle, `key_r` retains K0.
    - No accept: `key_r` and `rnd` are held.
- `start` is ignored outside IDLE. `rk_ready` is ignored outside OUTPUT.

## Timing
- Reset values: `busy` 0, `rk_valid` 0, `rk_out` 0, `rk_round` 0, `done` 0. The state is IDLE.
- Every output is registered.
- Latency: `start` sampled at edge E0 gives `rk_valid` = 1 with `rk_round` = 10 after edge E10, i.e. 10 cycles in EXPAND.
- Throughput in OUTPUT is one key per cycle when `rk_ready` is held high. The full stream after the first valid is 11 cycles, followed by the `done` pulse.
- Back-pressure: while `rk_valid & !rk_ready`, `rk_out` and `rk_round` are stable.
- `busy` falls in the same cycle that `done` pulses. `start` in that `done` cycle is accepted, because the state is already IDLE.
- `rst` asserted mid-EXPAND or mid-OUTPUT returns to IDLE with every output at its reset value on the next edge. No `done` is generated.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready` = 1 → first valid 10 cycles after start, carrying d014f9a8c9ee2589e13f0cc8b6630ca6 with round 10. Next cycle: ac7766f319fadc2128d12941575c006e with round 9.
- Same run continued → round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = key_in. `done` pulses exactly once, 11 cycles after the first valid.
- Random `rk_ready` back-pressure → sequence identical to the unstalled run. `rk_out` and `rk_round` are held stable during stalls.
- `start` pulsed during EXPAND and OUTPUT with a different key → ignored, and the output stream is unchanged.
- `rst` asserted at round 5 of OUTPUT → next cycle `rk_valid` = 0, `busy` = 0, `rk_out` = 0. A new start then produces a correct full stream.
- All-zero key → round 10 = b4ef5bcb3e92e21123e951cf6f8f188e. Compare 100 random keys against a software model.

Source files
------------

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decrypt-side key schedule: expands the cipher key forward to K10,
// then streams round keys 10..0 backwards over a valid/ready handshake.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  logic [7:0] sq_w;
  logic [7:0] inv_w;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0).
  always_comb begin
    sq_w  = a;
    inv_w = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq_w  = gf_mul(sq_w, sq_w);
      inv_w = gf_mul(inv_w, sq_w);
    end
  end

  assign c = inv_w ^ {inv_w[6:0], inv_w[7]} ^ {inv_w[5:0], inv_w[7:6]}
           ^ {inv_w[4:0], inv_w[7:5]} ^ {inv_w[3:0], inv_w[7:4]} ^ 8'h63;
endmodule

module aes_inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);
  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_OUTPUT} state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sbox_in, rot_w, t_w, rcw;
  logic [3:0]   rc_idx;
  logic [127:0] fwd_key, inv_key;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  i0, i1, i2, i3;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Going backwards, the original w3 is recovered as w2'^w3' before substitution.
  assign sbox_in = (state_q == ST_OUTPUT) ? (w2 ^ w3) : w3;
  assign rot_w   = {sbox_in[23:0], sbox_in[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      sbox u_sbox (
        .a (rot_w[gi*8 +: 8]),
        .c (t_w[gi*8 +: 8])
      );
    end
  endgenerate

  assign rc_idx = (state_q == ST_OUTPUT) ? (rnd_q - 4'd1) : rnd_q;
  assign rcw    = {rcon(rc_idx), 24'h000000};

  assign f0 = w0 ^ t_w ^ rcw;
  assign f1 = f0 ^ w1;
  assign f2 = f1 ^ w2;
  assign f3 = f2 ^ w3;
  assign fwd_key = {f0, f1, f2, f3};

  assign i3 = w3 ^ w2;
  assign i2 = w2 ^ w1;
  assign i1 = w1 ^ w0;
  assign i0 = w0 ^ t_w ^ rcw;
  assign inv_key = {i0, i1, i2, i3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          rnd_d   = 4'd0;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        key_d = fwd_key;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd9) state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (rk_ready) begin
          if (rnd_q != 4'd0) begin
            key_d = inv_key;
            rnd_d = rnd_q - 4'd1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign rk_valid = (state_q == ST_OUTPUT);
  assign rk_out   = key_q;
  assign rk_round = rnd_q;
  assign done     = done_q;
endmodule
